mel_frame_collector: RTL and testbench

//  Collects the serial stream of 16-bit mel filterbank energies, one coefficient per beat, into a full
//  N_COEF-wide parallel frame. Presents that frame to reshape_output over a valid/ready handshake.

---
 rtl/mel_frame_collector.sv | 115 +++++++++++
 tb/tb_mel_frame_collector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_frame_collector.sv
// Ping-pong frame collector: gathers N_COEF serial mel energies into a parallel frame
// and hands complete frames downstream over valid/ready.
module mel_frame_collector #(
  parameter int unsigned N_COEF = 40,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] out [N_COEF],
  output logic              m_valid,
  input  logic              m_ready,
  output logic              err_short,
  output logic              err_long,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned IDX_W = $clog2(N_COEF > 1 ? N_COEF : 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

  typedef enum logic {FILL, DROP} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] bank [2][N_COEF];
  logic [1:0]        full;
  logic              wr_sel, rd_sel;
  logic [IDX_W-1:0]  wr_idx, wr_idx_nx;
  logic              accept, consume;
  logic              store, commit, short_nx, long_nx;

  assign s_ready = (state == DROP) | ~full[wr_sel];
  assign m_valid = full[rd_sel];
  assign accept  = s_valid & s_ready;
  assign consume = m_valid & m_ready;

  always_comb begin
    for (int unsigned i = 0; i < N_COEF; i++) out[i] = bank[rd_sel][i];
  end

  // Next-state and write control
  always_comb begin
    state_nx  = state;
    wr_idx_nx = wr_idx;
    store     = 1'b0;
    commit    = 1'b0;
    short_nx  = 1'b0;
    long_nx   = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (wr_idx == LAST_IDX) begin
            store     = 1'b1;
            commit    = 1'b1;
            wr_idx_nx = '0;
            if (!s_last) begin
              long_nx  = 1'b1;
              state_nx = DROP;
            end
          end else if (s_last) begin
            wr_idx_nx = '0;
            short_nx  = 1'b1;
          end else begin
            store     = 1'b1;
            wr_idx_nx = wr_idx + IDX_W'(1);
          end
        end
      end
      DROP: begin
        if (accept && s_last) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < N_COEF; i++) bank[b][i] <= '0;
      full      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_idx    <= '0;
      frame_cnt <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      wr_idx    <= wr_idx_nx;
      err_short <= short_nx;
      err_long  <= long_nx;
      if (store) bank[wr_sel][wr_idx] <= s_data;
      // commit and consume always target different banks: a full bank is never written
      if (consume) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
        frame_cnt    <= frame_cnt + 16'd1;
      end
      if (commit) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
    end
  end

endmodule

// File: tb/tb_mel_frame_collector.sv
// Directed/table-driven bench for mel_frame_collector with a frame scoreboard.
module tb_mel_frame_collector;

  localparam int unsigned N = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [15:0] out [N];
  logic        m_valid, m_ready;
  logic        err_short, err_long;
  logic [15:0] frame_cnt;

  mel_frame_collector #(.N_COEF(N), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .out(out), .m_valid(m_valid), .m_ready(m_ready),
    .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d [N]; } frame_t;
  typedef struct { int n; int base; int last_at; int e_short; int e_long; int e_frames; } vec_t;

  int total = 0;
  int bad = 0;
  int stalls = 0;
  int timeouts = 0;
  int mode = 0;  // 0: m_ready low, 1: high, 2: random

  frame_t got_q[$];
  frame_t exp_q[$];
  int n_short = 0, n_long = 0, n_both = 0;
  int stab_chk = 0, stab_bad = 0;

  // m_ready driver
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_ready = (mode == 2) ? 1'($urandom_range(1)) : (mode == 1);
    end
  end

  // Monitor: captures delivered frames, error pulses, and stall stability
  logic   pv = 1'b0, pr = 1'b0;
  frame_t po;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        stab_chk++;
        if (!m_valid) stab_bad++;
        for (int i = 0; i < N; i++) if (out[i] != po.d[i]) stab_bad++;
      end
      if (m_valid && m_ready) begin
        frame_t f;
        for (int i = 0; i < N; i++) f.d[i] = out[i];
        got_q.push_back(f);
      end
      if (err_short) n_short++;
      if (err_long) n_long++;
      if (err_short && err_long) n_both++;
      pv = m_valid;
      pr = m_ready;
      for (int i = 0; i < N; i++) po.d[i] = out[i];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic send(input int d, input bit l);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = 16'(d); s_last = l;
    @(negedge clk);
    while (!s_ready && n < 5000) begin @(negedge clk); n++; end
    stalls += n;
    if (n >= 5000) timeouts++;
    @(posedge clk); #2;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic push_exp(input int base);
    frame_t f;
    for (int i = 0; i < N; i++) f.d[i] = 16'(base + i);
    exp_q.push_back(f);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 5000) begin cyc(); n++; end
    repeat (4) cyc();
  endtask

  int chk_ptr = 0;
  int cnt_base = 0;
  task automatic check_frames(input string name);
    chk({name, "_nframes"}, got_q.size(), exp_q.size());
    for (int k = chk_ptr; k < exp_q.size() && k < got_q.size(); k++) begin
      int mism;
      mism = 0;
      for (int i = 0; i < N; i++) if (got_q[k].d[i] != exp_q[k].d[i]) mism++;
      chk({name, "_data"}, mism, 0);
    end
    chk_ptr = exp_q.size();
    chk({name, "_frame_cnt"}, int'(frame_cnt), (exp_q.size() - cnt_base) % 65536);
  endtask

  function automatic int out_sum();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(out[i]);
    return s;
  endfunction

  vec_t tbl [9];

  initial begin
    tbl[0] = '{n:40, base:1,    last_at:40, e_short:0, e_long:0, e_frames:1};
    tbl[1] = '{n:10, base:50,   last_at:10, e_short:1, e_long:0, e_frames:0};
    tbl[2] = '{n:40, base:200,  last_at:40, e_short:0, e_long:0, e_frames:1};
    tbl[3] = '{n:45, base:1,    last_at:45, e_short:0, e_long:1, e_frames:1};
    tbl[4] = '{n:40, base:300,  last_at:40, e_short:0, e_long:0, e_frames:1};
    tbl[5] = '{n:1,  base:7,    last_at:1,  e_short:1, e_long:0, e_frames:0};
    tbl[6] = '{n:39, base:400,  last_at:39, e_short:1, e_long:0, e_frames:0};
    tbl[7] = '{n:41, base:500,  last_at:41, e_short:0, e_long:1, e_frames:1};
    tbl[8] = '{n:80, base:1000, last_at:80, e_short:0, e_long:1, e_frames:1};

    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_out", out_sum(), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rel_s_ready", int'(s_ready), 1);
    chk("rel_m_valid", int'(m_valid), 0);
    cyc();

    // Latency of first frame with consumer stalled
    for (int b = 1; b <= 39; b++) send(b, 1'b0);
    @(negedge clk);
    chk("lat_before_last", int'(m_valid), 0);
    cyc();
    send(40, 1'b1);
    @(negedge clk);
    chk("lat_m_valid", int'(m_valid), 1);
    chk("lat_out0", int'(out[0]), 1);
    chk("lat_out39", int'(out[39]), 40);
    cyc();
    push_exp(1);
    mode = 1;
    drain();
    check_frames("lat");

    // Table of frame shapes with consumer always ready
    foreach (tbl[v]) begin
      int s0, l0;
      s0 = n_short; l0 = n_long; stalls = 0;
      for (int b = 1; b <= tbl[v].n; b++) send(tbl[v].base + b - 1, b == tbl[v].last_at);
      if (tbl[v].e_frames != 0) push_exp(tbl[v].base);
      drain();
      chk($sformatf("vec%0d_err_short", v), n_short - s0, tbl[v].e_short);
      chk($sformatf("vec%0d_err_long", v), n_long - l0, tbl[v].e_long);
      chk($sformatf("vec%0d_stalls", v), stalls, 0);
      check_frames($sformatf("vec%0d", v));
    end

    // Back-pressure: three frames, consumer stalled
    mode = 0;
    repeat (3) cyc();
    for (int b = 0; b < 80; b++) send(100 + b, (b % 40) == 39);
    @(negedge clk);
    chk("bp_s_ready_full", int'(s_ready), 0);
    chk("bp_m_valid", int'(m_valid), 1);
    chk("bp_out0", int'(out[0]), 100);
    repeat (3) @(negedge clk);
    chk("bp_s_ready_hold", int'(s_ready), 0);
    chk("bp_out_hold", int'(out[39]), 139);
    cyc();
    mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_s_ready_consume_cyc", int'(s_ready), 0);
    @(negedge clk);
    chk("bp_s_ready_freed", int'(s_ready), 1);
    cyc();
    for (int b = 80; b < 120; b++) send(100 + b, (b % 40) == 39);
    push_exp(100); push_exp(140); push_exp(180);
    drain();
    check_frames("bp");

    // Random valid/ready against the scoreboard
    mode = 2;
    for (int f = 0; f < 200; f++) begin
      push_exp(2000 + f * 40);
      for (int i = 0; i < N; i++) begin
        while ($urandom_range(1) == 1) cyc();
        send(2000 + f * 40 + i, i == N - 1);
      end
    end
    drain();
    mode = 1;
    drain();
    check_frames("rand");

    // Reset mid-frame with one bank pending
    mode = 0;
    repeat (3) cyc();
    for (int b = 0; b < 40; b++) send(700 + b, b == 39);
    for (int b = 0; b < 20; b++) send(800 + b, 1'b0);
    @(negedge clk);
    chk("mid_m_valid_pre", int'(m_valid), 1);
    cyc();
    reset = 1'b1;
    #1;
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_out", out_sum(), 0);
    repeat (2) cyc();
    reset = 1'b0;
    cnt_base = exp_q.size();
    @(negedge clk);
    chk("mid_rel_s_ready", int'(s_ready), 1);
    chk("mid_rel_frame_cnt", int'(frame_cnt), 0);
    chk("mid_rel_err", int'(err_short) + int'(err_long), 0);
    cyc();
    mode = 1;
    for (int b = 0; b < 40; b++) send(900 + b, b == 39);
    push_exp(900);
    drain();
    check_frames("mid");

    chk("err_exclusive", n_both, 0);
    chk("stall_stable", stab_bad, 0);
    chk("stall_checks_seen", int'(stab_chk > 0), 1);
    chk("send_timeouts", timeouts, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
